sound_sequencer: RTL and testbench
==================================

# sound_sequencer

Event-to-tone sequencer sitting directly upstream of the speaker stage. It converts single-cycle game event pulses into timed level signals: a wrong-guess event becomes a fixed-length `activate_sound` interval, and a solve event becomes a `victory` beep pattern of N on/off bursts. Outputs drive the speaker's `activate_sound` and `victory` inputs directly and are never high together.

## Interface
- `ERR_CYCLES`, default 50_000_000: duration of the error tone, in clk cycles. Must be ≥1.
- `WIN_ON_CYCLES`, default 12_500_000: length of each victory beep, in clk cycles. Must be ≥1.
- `WIN_OFF_CYCLES`, default 12_500_000: gap between victory beeps, in clk cycles. Must be ≥1.
- `WIN_BEEPS`, default 3: number of victory beeps. Must be ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `err_pulse`  in  1  one-cycle wrong-guess event.
- `win_pulse`  in  1  one-cycle code-solved event.
- `activate_sound`  out  1  error tone enable to the speaker.
- `victory`  out  1  victory tone enable to the speaker.
- `busy`  out  1  high whenever the state is not IDLE.
- Reset is `rst`, asynchronous, active-high; the clock is `clk`.

## Operation
- FSM states:
  - IDLE
  - ERR: `activate_sound`=1.
  - WIN_ON: `victory`=1.
  - WIN_OFF: both outputs 0.
- A 32-bit down-counter `cnt` holds the remaining cycles in the current state. An 8-bit `beeps_left` counts the victory beeps still to play.
- IDLE:
  - On `win_pulse`: go to WIN_ON, load `cnt`=WIN_ON_CYCLES-1 and `beeps_left`=WIN_BEEPS-1.
  - Else on `err_pulse`: go to ERR, load `cnt`=ERR_CYCLES-1.
  - If both pulses arrive in the same cycle, the win event takes priority.
- ERR:
  - `win_pulse` preempts: go to WIN_ON and load as from IDLE.
  - `err_pulse` retriggers: reload `cnt`=ERR_CYCLES-1.
  - When `cnt`==0, go to IDLE.
- WIN_ON:
  - When `cnt`==0: if `beeps_left`==0, go to IDLE. Otherwise go to WIN_OFF and load `cnt`=WIN_OFF_CYCLES-1.
- WIN_OFF:
  - When `cnt`==0: go to WIN_ON, load `cnt`=WIN_ON_CYCLES-1, and decrement `beeps_left`.
- Both pulses are ignored while in WIN_ON or WIN_OFF. The victory pattern always completes.
- The pattern has no trailing gap after the last beep.
- `activate_sound` and `victory` are mutually exclusive on every cycle.

## Timing
- All outputs are registered and decoded from the state register.
- Reset values: `activate_sound`=0, `victory`=0, `busy`=0, state IDLE, `cnt`=0, `beeps_left`=0.
- Asserting `rst` forces all outputs to 0 immediately, mid-sequence included.
- An event sampled at edge k raises its output from cycle k+1. The output stays high for exactly the configured cycle count.
- On preemption (ERR to WIN_ON), `activate_sound` falls and `victory` rises on the same edge.
- Total victory sequence length: WIN_BEEPS·WIN_ON_CYCLES + (WIN_BEEPS-1)·WIN_OFF_CYCLES cycles.
- A retrigger sampled at edge k holds `activate_sound` through cycle k+ERR_CYCLES.

## Configuration
- Macro `SOUND_SEQUENCER_MUTE_EN`:
  - When defined, adds input port `mute` (1 bit). While `mute`=1, `activate_sound` and `victory` are forced to 0, but the FSM, counters and `busy` keep running unchanged. Unmuting mid-sequence resumes output at the current position.
  - When undefined, the port does not exist and the outputs follow the FSM directly.

## Structure
- Shared package `sound_pkg` holds:
  - the state encoding constants (IDLE, ERR, WIN_ON, WIN_OFF);
  - the default duration constants;
  - the counter widths (32-bit `cnt`, 8-bit `beeps_left`).
- One sub-module, `snd_timer`: a loadable 32-bit down-counter with inputs `load`/`load_val` and output `zero`. The FSM instantiates it once.

## Test plan
Benches use ERR_CYCLES=4, WIN_ON_CYCLES=3, WIN_OFF_CYCLES=2, WIN_BEEPS=3.
- **Error tone:** `err_pulse` at edge 10 → `activate_sound`=1 and `busy`=1 for cycles 11–14, both 0 at cycle 15; `victory` stays 0 throughout.
- **Victory pattern:** `win_pulse` at edge 10 → `victory` is 1 for cycles 11–13, 0 for 14–15, 1 for 16–18, 0 for 19–20, 1 for 21–23. `busy` falls at cycle 24.
- **Simultaneous events:** `err_pulse` and `win_pulse` together at edge 10 → identical to the victory-pattern scenario; `activate_sound` is never 1.
- **Preemption and retrigger:**
  - `err_pulse` at edge 10 and `win_pulse` at edge 12 → `activate_sound` is 1 for cycles 11–12, `victory` rises at cycle 13; the outputs are never both 1.
  - Separately, `err_pulse` at edges 10 and 13 → `activate_sound` is 1 for cycles 11–17.
- **Reset mid-sequence:** `rst` asserted during WIN_OFF → all outputs are 0 immediately. After release, `err_pulse` starts a normal 4-cycle tone.
- **Mute (with `SOUND_SEQUENCER_MUTE_EN`):** `mute`=1 during cycles 11–15 of a victory pattern → `victory` is 0 in that window, `busy` stays 1, and the pattern still ends at cycle 24.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared definitions for the sound sequencer: FSM state encoding, default
// tone durations and the counter widths used by the FSM and its timer.
package sound_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ERR     = 2'd1,
        ST_WIN_ON  = 2'd2,
        ST_WIN_OFF = 2'd3
    } state_e;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned BEEPS_W = 8;

    localparam int unsigned DEF_ERR_CYCLES     = 50_000_000;
    localparam int unsigned DEF_WIN_ON_CYCLES  = 12_500_000;
    localparam int unsigned DEF_WIN_OFF_CYCLES = 12_500_000;
    localparam int unsigned DEF_WIN_BEEPS      = 3;

endpackage

// File: rtl/snd_timer.sv
// Loadable down-counter holding the cycles remaining in the current FSM state.
// It saturates at zero; a load always wins over counting.
module snd_timer
    import sound_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sound_sequencer.sv
// Turns one-cycle game event pulses into timed speaker enables: an error tone
// and a multi-beep victory pattern. Optional macro: SOUND_SEQUENCER_MUTE_EN.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned ERR_CYCLES     = DEF_ERR_CYCLES,
    parameter int unsigned WIN_ON_CYCLES  = DEF_WIN_ON_CYCLES,
    parameter int unsigned WIN_OFF_CYCLES = DEF_WIN_OFF_CYCLES,
    parameter int unsigned WIN_BEEPS      = DEF_WIN_BEEPS
) (
    input  logic clk,
    input  logic rst,
    input  logic err_pulse,
    input  logic win_pulse,
`ifdef SOUND_SEQUENCER_MUTE_EN
    input  logic mute,
`endif
    output logic activate_sound,
    output logic victory,
    output logic busy
);

    localparam logic [CNT_W-1:0]   ERR_LOAD   = CNT_W'(ERR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   ON_LOAD    = CNT_W'(WIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]   OFF_LOAD   = CNT_W'(WIN_OFF_CYCLES - 1);
    localparam logic [BEEPS_W-1:0] BEEPS_LOAD = BEEPS_W'(WIN_BEEPS - 1);

    state_e             state_q, state_d;
    logic [BEEPS_W-1:0] beeps_q, beeps_d;
    logic               load;
    logic [CNT_W-1:0]   load_val;
    logic               cnt_zero;
    logic               act_q, vic_q, busy_q;

    snd_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .zero     (cnt_zero)
    );

    // NOTE: every signal gets a default before the case so no latches are inferred.
    always_comb begin
        state_d  = state_q;
        beeps_d  = beeps_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (win_pulse) begin
                    state_d  = ST_WIN_ON;
                    load     = 1'b1;
                    load_val = ON_LOAD;
                    beeps_d  = BEEPS_LOAD;
                end else if (err_pulse) begin
                    state_d  = ST_ERR;
                    load     = 1'b1;
                    load_val = ERR_LOAD;
                end else if (state_q == ST_ERR && cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WIN_ON: begin
                if (cnt_zero) begin
                    if (beeps_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_WIN_OFF;
                        load     = 1'b1;
                        load_val = OFF_LOAD;
                    end
                end
            end
            ST_WIN_OFF: begin
                if (cnt_zero) begin
                    state_d  = ST_WIN_ON;
                    load     = 1'b1;
                    load_val = ON_LOAD;
                    beeps_d  = beeps_q - BEEPS_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beeps_q <= '0;
            act_q   <= 1'b0;
            vic_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beeps_q <= beeps_d;
            act_q   <= (state_d == ST_ERR);
            vic_q   <= (state_d == ST_WIN_ON);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

`ifdef SOUND_SEQUENCER_MUTE_EN
    assign activate_sound = act_q & ~mute;
    assign victory        = vic_q & ~mute;
`else
    assign activate_sound = act_q;
    assign victory        = vic_q;
`endif
    assign busy = busy_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed self-checking bench for sound_sequencer with short durations.
// Define SOUND_SEQUENCER_MUTE_EN to also exercise the mute input.
module tb_sound_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic err_pulse;
    logic win_pulse;
    logic activate_sound;
    logic victory;
    logic busy;
`ifdef SOUND_SEQUENCER_MUTE_EN
    logic mute_s = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sound_sequencer #(
        .ERR_CYCLES     (4),
        .WIN_ON_CYCLES  (3),
        .WIN_OFF_CYCLES (2),
        .WIN_BEEPS      (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .err_pulse      (err_pulse),
        .win_pulse      (win_pulse),
`ifdef SOUND_SEQUENCER_MUTE_EN
        .mute           (mute_s),
`endif
        .activate_sound (activate_sound),
        .victory        (victory),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Drive inputs for the next edge, take that edge, then sample 1 ns later.
    // Sample taken after "edge c-1" is the value of "cycle c".
    task automatic step(input logic e, input logic w);
        @(negedge clk);
        err_pulse = e;
        win_pulse = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        err_pulse = 1'b0;
        win_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({activate_sound, victory, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got act/vic/busy=%b expected 000", {activate_sound, victory, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);
        n_checks++;
        if ({activate_sound, victory, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got act/vic/busy=%b expected 000", {activate_sound, victory, busy});
        end
    endtask

    task automatic test_err_tone;
        logic ea, ev, eb;
        for (int c = 11; c <= 16; c++) begin
            step(c == 11, 1'b0);
            ea = (c >= 11 && c <= 14);
            ev = 1'b0;
            eb = ea;
            n_checks++;
            if ({activate_sound, victory, busy} !== {ea, ev, eb}) begin
                n_fail++;
                $display("FAIL err_tone cycle %0d: got act/vic/busy=%b expected %b",
                         c, {activate_sound, victory, busy}, {ea, ev, eb});
            end
        end
    endtask

    // Victory pattern, optionally with a simultaneous err_pulse at edge 10.
    task automatic test_victory(input logic with_err);
        logic ea, ev, eb;
        for (int c = 11; c <= 25; c++) begin
            step(with_err && c == 11, c == 11);
            ea = 1'b0;
            ev = (c >= 11 && c <= 13) || (c >= 16 && c <= 18) || (c >= 21 && c <= 23);
            eb = (c >= 11 && c <= 23);
            n_checks++;
            if ({activate_sound, victory, busy} !== {ea, ev, eb}) begin
                n_fail++;
                $display("FAIL victory(simul=%0d) cycle %0d: got act/vic/busy=%b expected %b",
                         with_err, c, {activate_sound, victory, busy}, {ea, ev, eb});
            end
        end
    endtask

    task automatic test_preempt;
        logic ea, ev, eb;
        for (int c = 11; c <= 27; c++) begin
            step(c == 11, c == 13);
            ea = (c >= 11 && c <= 12);
            ev = (c >= 13 && c <= 15) || (c >= 18 && c <= 20) || (c >= 23 && c <= 25);
            eb = (c >= 11 && c <= 25);
            n_checks++;
            if ({activate_sound, victory, busy} !== {ea, ev, eb}) begin
                n_fail++;
                $display("FAIL preempt cycle %0d: got act/vic/busy=%b expected %b",
                         c, {activate_sound, victory, busy}, {ea, ev, eb});
            end
            n_checks++;
            if ((activate_sound & victory) !== 1'b0) begin
                n_fail++;
                $display("FAIL preempt_exclusive cycle %0d: got both=%b expected 0", c, activate_sound & victory);
            end
        end
    endtask

    task automatic test_retrigger;
        logic ea;
        for (int c = 11; c <= 19; c++) begin
            step(c == 11 || c == 14, 1'b0);
            ea = (c >= 11 && c <= 17);
            n_checks++;
            if ({activate_sound, victory, busy} !== {ea, 1'b0, ea}) begin
                n_fail++;
                $display("FAIL retrigger cycle %0d: got act/vic/busy=%b expected %b",
                         c, {activate_sound, victory, busy}, {ea, 1'b0, ea});
            end
        end
    endtask

    task automatic test_reset_mid;
        // Run victory into its first gap (cycle 15 is WIN_OFF).
        for (int c = 11; c <= 15; c++) step(c == 11, 1'b0 || c == 11 ? c == 11 : 1'b0);
        n_checks++;
        if ({activate_sound, victory, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got act/vic/busy=%b expected 001", {activate_sound, victory, busy});
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({activate_sound, victory, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_async: got act/vic/busy=%b expected 000", {activate_sound, victory, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);
        for (int c = 11; c <= 16; c++) begin
            step(c == 11, 1'b0);
            n_checks++;
            if ({activate_sound, victory, busy} !== {c <= 14, 1'b0, c <= 14}) begin
                n_fail++;
                $display("FAIL reset_mid_err cycle %0d: got act/vic/busy=%b expected %b",
                         c, {activate_sound, victory, busy}, {c <= 14, 1'b0, c <= 14});
            end
        end
    endtask

`ifdef SOUND_SEQUENCER_MUTE_EN
    task automatic test_mute;
        logic ev, eb;
        for (int c = 11; c <= 25; c++) begin
            mute_s = (c >= 11 && c <= 15);
            step(1'b0, c == 11);
            ev = ((c >= 16 && c <= 18) || (c >= 21 && c <= 23));
            eb = (c >= 11 && c <= 23);
            n_checks++;
            if ({activate_sound, victory, busy} !== {1'b0, ev, eb}) begin
                n_fail++;
                $display("FAIL mute cycle %0d: got act/vic/busy=%b expected %b",
                         c, {activate_sound, victory, busy}, {1'b0, ev, eb});
            end
        end
        mute_s = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_err_tone();
        idle_cycles(3);
        test_victory(1'b0);
        idle_cycles(3);
        test_victory(1'b1);
        idle_cycles(3);
        test_preempt();
        idle_cycles(3);
        test_retrigger();
        idle_cycles(3);
        test_reset_mid();
        idle_cycles(3);
`ifdef SOUND_SEQUENCER_MUTE_EN
        test_mute();
        idle_cycles(3);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
